// File: rtl/cpu_axil_bridge.sv
// cpu_axil_bridge
//   Turns single-byte CPU bus accesses into 32-bit AXI-Lite master
//   transactions on the SD controller register path. A byte write is issued
//   as a one-lane strobed write. A byte read returns the addressed lane of
//   the 32-bit word. The CPU is stalled through o_rdy until the transaction
//   completes.
//
// Parameters
//   ADDR_WIDTH : CPU byte-address width into the register window (>= 3)
//   AXI_BASE   : constant OR-ed into every emitted AXI address
//
// Ports
//   i_clk, i_reset_n        : clock, asynchronous active-low reset
//   i_cs, i_rwb             : CPU chip select, 1 = read / 0 = write
//   i_addr, i_data          : CPU byte address and write data
//   o_data                  : read data, held until the next read completes
//   o_rdy                   : 0 stalls the CPU
//   o_err                   : last completed transaction got a non-OKAY response
//   M_AXIL_AW*/W*/B*/AR*/R* : AXI-Lite master channels
module cpu_axil_bridge #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] AXI_BASE   = 32'h0
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cs,
  input  logic                  i_rwb,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_data,
  output logic [7:0]            o_data,
  output logic                  o_rdy,
  output logic                  o_err,

  output logic                  M_AXIL_AWVALID,
  input  logic                  M_AXIL_AWREADY,
  output logic [31:0]           M_AXIL_AWADDR,

  output logic                  M_AXIL_WVALID,
  input  logic                  M_AXIL_WREADY,
  output logic [31:0]           M_AXIL_WDATA,
  output logic [3:0]            M_AXIL_WSTRB,

  input  logic                  M_AXIL_BVALID,
  output logic                  M_AXIL_BREADY,
  input  logic [1:0]            M_AXIL_BRESP,

  output logic                  M_AXIL_ARVALID,
  input  logic                  M_AXIL_ARREADY,
  output logic [31:0]           M_AXIL_ARADDR,

  input  logic                  M_AXIL_RVALID,
  output logic                  M_AXIL_RREADY,
  input  logic [31:0]           M_AXIL_RDATA,
  input  logic [1:0]            M_AXIL_RRESP
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_data;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic [7:0]            r_rdata;
  logic                  r_err;

  logic                  w_start;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic                  w_b_accept;
  logic                  w_r_accept;
  logic [31:0]           w_word_addr;
  logic [7:0]            w_rd_lane;

  // A new access is accepted only from IDLE; DONE waits for i_cs to drop so
  // a CPU holding i_cs gets exactly one transaction.
  assign w_start    = (r_state == IDLE) && i_cs;

  // Address and data channels complete independently; a channel counts as
  // done if it already handshook or is handshaking this cycle.
  assign w_aw_done  = !r_awvalid || M_AXIL_AWREADY;
  assign w_w_done   = !r_wvalid  || M_AXIL_WREADY;
  assign w_b_accept = (r_state == WR_RESP) && M_AXIL_BVALID;
  assign w_r_accept = (r_state == RD_DATA) && M_AXIL_RVALID;

  always_comb begin
    w_word_addr = '0;
    w_word_addr[ADDR_WIDTH-1:2] = r_addr[ADDR_WIDTH-1:2];
  end

  always_comb begin
    w_rd_lane = '0;
    case (r_addr[1:0])
      2'd0: w_rd_lane = M_AXIL_RDATA[7:0];
      2'd1: w_rd_lane = M_AXIL_RDATA[15:8];
      2'd2: w_rd_lane = M_AXIL_RDATA[23:16];
      2'd3: w_rd_lane = M_AXIL_RDATA[31:24];
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and combinational outputs
  always_comb begin
    w_next_state  = r_state;
    o_rdy         = 1'b1;
    M_AXIL_BREADY = 1'b0;
    M_AXIL_RREADY = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_cs) begin
          o_rdy        = 1'b0;
          w_next_state = i_rwb ? RD_ADDR : WR_ADDR_DATA;
        end
      end
      WR_ADDR_DATA: begin
        o_rdy = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        o_rdy         = 1'b0;
        M_AXIL_BREADY = 1'b1;
        if (M_AXIL_BVALID) begin
          w_next_state = DONE;
        end
      end
      RD_ADDR: begin
        o_rdy = 1'b0;
        if (M_AXIL_ARREADY) begin
          w_next_state = RD_DATA;
        end
      end
      RD_DATA: begin
        o_rdy         = 1'b0;
        M_AXIL_RREADY = 1'b1;
        if (M_AXIL_RVALID) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        if (!i_cs) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Captured request and registered VALIDs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr    <= '0;
      r_data    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
    end else if (w_start) begin
      r_addr    <= i_addr;
      r_data    <= i_data;
      r_awvalid <= !i_rwb;
      r_wvalid  <= !i_rwb;
      r_arvalid <= i_rwb;
    end else begin
      if (r_awvalid && M_AXIL_AWREADY) begin
        r_awvalid <= 1'b0;
      end
      if (r_wvalid && M_AXIL_WREADY) begin
        r_wvalid <= 1'b0;
      end
      if (r_arvalid && M_AXIL_ARREADY) begin
        r_arvalid <= 1'b0;
      end
    end
  end

  // Read data and error status only move when a response is accepted
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_b_accept) begin
      r_err   <= (M_AXIL_BRESP != 2'b00);
    end else if (w_r_accept) begin
      r_rdata <= w_rd_lane;
      r_err   <= (M_AXIL_RRESP != 2'b00);
    end
  end

  assign o_data         = r_rdata;
  assign o_err          = r_err;

  assign M_AXIL_AWVALID = r_awvalid;
  assign M_AXIL_AWADDR  = AXI_BASE | w_word_addr;
  assign M_AXIL_WVALID  = r_wvalid;
  assign M_AXIL_WDATA   = {4{r_data}};
  assign M_AXIL_WSTRB   = 4'b0001 << r_addr[1:0];
  assign M_AXIL_ARVALID = r_arvalid;
  assign M_AXIL_ARADDR  = AXI_BASE | w_word_addr;

endmodule

// File: tb/tb_cpu_axil_bridge.sv
// Testbench for cpu_axil_bridge: a byte-array reference model predicts every
// AXI request and CPU-visible result into queues; a monitor pops and compares
// on each handshake, and a behavioural AXI-Lite slave with per-channel delays
// and injectable error responses answers the bridge.
module tb_cpu_axil_bridge;

  localparam int          AW   = 8;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_cs;
  logic        i_rwb;
  logic [7:0]  i_addr;
  logic [7:0]  i_data;
  logic [7:0]  o_data;
  logic        o_rdy;
  logic        o_err;
  logic        M_AXIL_AWVALID, M_AXIL_AWREADY;
  logic [31:0] M_AXIL_AWADDR;
  logic        M_AXIL_WVALID, M_AXIL_WREADY;
  logic [31:0] M_AXIL_WDATA;
  logic [3:0]  M_AXIL_WSTRB;
  logic        M_AXIL_BVALID, M_AXIL_BREADY;
  logic [1:0]  M_AXIL_BRESP;
  logic        M_AXIL_ARVALID, M_AXIL_ARREADY;
  logic [31:0] M_AXIL_ARADDR;
  logic        M_AXIL_RVALID, M_AXIL_RREADY;
  logic [31:0] M_AXIL_RDATA;
  logic [1:0]  M_AXIL_RRESP;

  cpu_axil_bridge #(
    .ADDR_WIDTH(AW),
    .AXI_BASE  (BASE)
  ) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_cs           (i_cs),
    .i_rwb          (i_rwb),
    .i_addr         (i_addr),
    .i_data         (i_data),
    .o_data         (o_data),
    .o_rdy          (o_rdy),
    .o_err          (o_err),
    .M_AXIL_AWVALID (M_AXIL_AWVALID),
    .M_AXIL_AWREADY (M_AXIL_AWREADY),
    .M_AXIL_AWADDR  (M_AXIL_AWADDR),
    .M_AXIL_WVALID  (M_AXIL_WVALID),
    .M_AXIL_WREADY  (M_AXIL_WREADY),
    .M_AXIL_WDATA   (M_AXIL_WDATA),
    .M_AXIL_WSTRB   (M_AXIL_WSTRB),
    .M_AXIL_BVALID  (M_AXIL_BVALID),
    .M_AXIL_BREADY  (M_AXIL_BREADY),
    .M_AXIL_BRESP   (M_AXIL_BRESP),
    .M_AXIL_ARVALID (M_AXIL_ARVALID),
    .M_AXIL_ARREADY (M_AXIL_ARREADY),
    .M_AXIL_ARADDR  (M_AXIL_ARADDR),
    .M_AXIL_RVALID  (M_AXIL_RVALID),
    .M_AXIL_RREADY  (M_AXIL_RREADY),
    .M_AXIL_RDATA   (M_AXIL_RDATA),
    .M_AXIL_RRESP   (M_AXIL_RRESP)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } resp_t;

  typedef struct {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wbeat_t;

  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_ar_q[$];
  wbeat_t      exp_w_q[$];
  resp_t       exp_resp_q[$];
  bit          err_q[$];

  logic [7:0]  ref_mem [256];
  logic [7:0]  ref_odata;
  logic [31:0] slv_mem [64];

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_aw = 0, cnt_b = 0, bready_cycles = 0;
  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed register window, one access at a time.
  task automatic model_access(input bit rd, input logic [7:0] a, input logic [7:0] d, input bit err);
    resp_t       r;
    wbeat_t      w;
    int          lane;
    logic [31:0] waddr;
    lane  = a % 4;
    waddr = BASE | (32'(a) & 32'hFFFF_FFFC);
    err_q.push_back(err);
    if (rd) begin
      exp_ar_q.push_back(waddr);
      ref_odata = ref_mem[a];
    end else begin
      exp_aw_q.push_back(waddr);
      w.wdata = 32'h0101_0101 * 32'(d);
      w.wstrb = 4'(1 << lane);
      exp_w_q.push_back(w);
      if (!err) ref_mem[a] = d;
    end
    r.data = ref_odata;
    r.err  = err;
    exp_resp_q.push_back(r);
  endtask

  // One CPU access; low_cycles counts sampled cycles with o_rdy=0.
  task automatic cpu_access(input bit rd, input logic [7:0] a, input logic [7:0] d,
                            input bit err, input int hold, output int low_cycles);
    model_access(rd, a, d, err);
    @(posedge i_clk); #1;
    i_cs = 1'b1; i_rwb = rd; i_addr = a; i_data = d;
    low_cycles = 0;
    @(negedge i_clk);
    while (!o_rdy && low_cycles < 300) begin
      low_cycles++;
      @(posedge i_clk); #1;
      i_addr = 8'($urandom); i_data = 8'($urandom); i_rwb = 1'($urandom);
      @(negedge i_clk);
    end
    if (low_cycles >= 300) chk("rdy_timeout", 32'(low_cycles), 32'd0);
    repeat (hold) begin
      @(posedge i_clk); #1;
      @(negedge i_clk);
      chk("rdy_held_cs", 32'(o_rdy), 32'd1);
    end
    @(posedge i_clk); #1;
    i_cs = 1'b0;
    @(posedge i_clk);
  endtask

  // Behavioural AXI-Lite slave
  initial begin
    bit          hs_aw, hs_w, hs_b, hs_ar, hs_r;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [3:0]  c_wstrb;
    bit          aw_have, w_have, b_busy, ar_have, s_berr, s_rerr;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int unsigned aw_ctr, w_ctr, b_ctr, ar_ctr, r_ctr;
    aw_have = 0; w_have = 0; b_busy = 0; ar_have = 0; s_berr = 0; s_rerr = 0;
    s_awaddr = '0; s_wdata = '0; s_araddr = '0; s_wstrb = '0;
    aw_ctr = 0; w_ctr = 0; b_ctr = 0; ar_ctr = 0; r_ctr = 0;
    M_AXIL_AWREADY = 0; M_AXIL_WREADY = 0; M_AXIL_BVALID = 0; M_AXIL_BRESP = '0;
    M_AXIL_ARREADY = 0; M_AXIL_RVALID = 0; M_AXIL_RDATA = '0; M_AXIL_RRESP = '0;
    forever begin
      @(negedge i_clk);
      hs_aw = i_reset_n && M_AXIL_AWVALID && M_AXIL_AWREADY;
      hs_w  = i_reset_n && M_AXIL_WVALID  && M_AXIL_WREADY;
      hs_b  = i_reset_n && M_AXIL_BVALID  && M_AXIL_BREADY;
      hs_ar = i_reset_n && M_AXIL_ARVALID && M_AXIL_ARREADY;
      hs_r  = i_reset_n && M_AXIL_RVALID  && M_AXIL_RREADY;
      c_awaddr = M_AXIL_AWADDR; c_wdata = M_AXIL_WDATA;
      c_wstrb  = M_AXIL_WSTRB;  c_araddr = M_AXIL_ARADDR;
      @(posedge i_clk); #1;
      if (!i_reset_n) begin
        aw_have = 0; w_have = 0; b_busy = 0; ar_have = 0;
        aw_ctr = 0; w_ctr = 0; b_ctr = 0; ar_ctr = 0; r_ctr = 0;
        M_AXIL_AWREADY = 0; M_AXIL_WREADY = 0; M_AXIL_BVALID = 0;
        M_AXIL_ARREADY = 0; M_AXIL_RVALID = 0;
      end else begin
        if (hs_b) begin b_busy = 0; aw_have = 0; w_have = 0; end
        if (hs_r) ar_have = 0;
        if (hs_aw) begin aw_have = 1; s_awaddr = c_awaddr; aw_ctr = 0; end
        if (hs_w)  begin w_have = 1; s_wdata = c_wdata; s_wstrb = c_wstrb; w_ctr = 0; end
        if (hs_ar) begin
          ar_have = 1; s_araddr = c_araddr; ar_ctr = 0; r_ctr = 0;
          s_rerr = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
        end
        if (aw_have && w_have && !b_busy) begin
          b_busy = 1; b_ctr = 0;
          s_berr = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
          if (!s_berr)
            for (int unsigned i = 0; i < 4; i++)
              if (s_wstrb[i]) slv_mem[s_awaddr[7:2]][i*8 +: 8] = s_wdata[i*8 +: 8];
        end
        M_AXIL_AWREADY = M_AXIL_AWVALID && !aw_have && (aw_ctr >= aw_delay);
        if (M_AXIL_AWVALID && !aw_have && !M_AXIL_AWREADY) aw_ctr++;
        M_AXIL_WREADY = M_AXIL_WVALID && !w_have && (w_ctr >= w_delay);
        if (M_AXIL_WVALID && !w_have && !M_AXIL_WREADY) w_ctr++;
        M_AXIL_ARREADY = M_AXIL_ARVALID && !ar_have && (ar_ctr >= ar_delay);
        if (M_AXIL_ARVALID && !ar_have && !M_AXIL_ARREADY) ar_ctr++;
        M_AXIL_BVALID = b_busy && (b_ctr >= b_delay);
        M_AXIL_BRESP  = s_berr ? 2'b10 : 2'b00;
        if (b_busy && !M_AXIL_BVALID) b_ctr++;
        M_AXIL_RVALID = ar_have && (r_ctr >= r_delay);
        M_AXIL_RDATA  = slv_mem[s_araddr[7:2]];
        M_AXIL_RRESP  = s_rerr ? 2'b10 : 2'b00;
        if (ar_have && !M_AXIL_RVALID) r_ctr++;
      end
    end
  end

  // Monitor: compares each handshake and each response against the queues
  initial begin
    bit          p_resp, p_awh, p_wh, p_arh, p_awd, p_wd, p_ard;
    logic [31:0] h_awaddr, h_wdata, h_araddr;
    logic [3:0]  h_wstrb;
    resp_t       r;
    wbeat_t      w;
    p_resp = 0; p_awh = 0; p_wh = 0; p_arh = 0; p_awd = 0; p_wd = 0; p_ard = 0;
    h_awaddr = '0; h_wdata = '0; h_araddr = '0; h_wstrb = '0;
    forever begin
      @(negedge i_clk);
      if (!i_reset_n) begin
        p_resp = 0; p_awh = 0; p_wh = 0; p_arh = 0; p_awd = 0; p_wd = 0; p_ard = 0;
      end else begin
        if (p_resp) begin
          if (exp_resp_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
          else begin
            r = exp_resp_q.pop_front();
            chk("o_data", 32'(o_data), 32'(r.data));
            chk("o_err", 32'(o_err), 32'(r.err));
          end
        end
        if (p_awh) begin
          chk("awvalid_hold", 32'(M_AXIL_AWVALID), 32'd1);
          chk("awaddr_stable", M_AXIL_AWADDR, h_awaddr);
        end
        if (p_wh) begin
          chk("wvalid_hold", 32'(M_AXIL_WVALID), 32'd1);
          chk("wdata_stable", M_AXIL_WDATA, h_wdata);
          chk("wstrb_stable", 32'(M_AXIL_WSTRB), 32'(h_wstrb));
        end
        if (p_arh) begin
          chk("arvalid_hold", 32'(M_AXIL_ARVALID), 32'd1);
          chk("araddr_stable", M_AXIL_ARADDR, h_araddr);
        end
        if (p_awd) chk("awvalid_drop", 32'(M_AXIL_AWVALID), 32'd0);
        if (p_wd)  chk("wvalid_drop", 32'(M_AXIL_WVALID), 32'd0);
        if (p_ard) chk("arvalid_drop", 32'(M_AXIL_ARVALID), 32'd0);

        p_awh = M_AXIL_AWVALID && !M_AXIL_AWREADY; h_awaddr = M_AXIL_AWADDR;
        p_wh  = M_AXIL_WVALID  && !M_AXIL_WREADY;  h_wdata = M_AXIL_WDATA; h_wstrb = M_AXIL_WSTRB;
        p_arh = M_AXIL_ARVALID && !M_AXIL_ARREADY; h_araddr = M_AXIL_ARADDR;
        p_awd = M_AXIL_AWVALID && M_AXIL_AWREADY;
        p_wd  = M_AXIL_WVALID  && M_AXIL_WREADY;
        p_ard = M_AXIL_ARVALID && M_AXIL_ARREADY;
        p_resp = (M_AXIL_BVALID && M_AXIL_BREADY) || (M_AXIL_RVALID && M_AXIL_RREADY);

        if (p_awd) begin
          cnt_aw++;
          if (exp_aw_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
          else chk("awaddr", M_AXIL_AWADDR, exp_aw_q.pop_front());
        end
        if (p_wd) begin
          if (exp_w_q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
          else begin
            w = exp_w_q.pop_front();
            chk("wdata", M_AXIL_WDATA, w.wdata);
            chk("wstrb", 32'(M_AXIL_WSTRB), 32'(w.wstrb));
          end
        end
        if (p_ard) begin
          if (exp_ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
          else chk("araddr", M_AXIL_ARADDR, exp_ar_q.pop_front());
        end
        if (M_AXIL_BREADY) bready_cycles++;
        if (M_AXIL_BVALID && M_AXIL_BREADY) cnt_b++;
      end
    end
  end

  // Stimulus
  initial begin
    int low, b0, aw0, br0;
    bit rd, err;
    logic [7:0] a, d;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int unsigned i = 0; i < 64; i++) slv_mem[i] = 32'h0;
    slv_mem[2] = 32'h1122_3344;
    ref_mem[8'h08] = 8'h44; ref_mem[8'h09] = 8'h33;
    ref_mem[8'h0A] = 8'h22; ref_mem[8'h0B] = 8'h11;
    ref_odata = 8'h00;
    i_reset_n = 1'b0; i_cs = 1'b0; i_rwb = 1'b0; i_addr = '0; i_data = '0;

    #22;
    chk("rst_o_rdy", 32'(o_rdy), 32'd1);
    chk("rst_o_data", 32'(o_data), 32'd0);
    chk("rst_o_err", 32'(o_err), 32'd0);
    chk("rst_valids", {29'd0, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_ARVALID}, 32'd0);
    chk("rst_readys", {30'd0, M_AXIL_BREADY, M_AXIL_RREADY}, 32'd0);
    @(posedge i_clk); #1;
    i_reset_n = 1'b1;

    // Zero-wait write
    br0 = bready_cycles;
    cpu_access(0, 8'h05, 8'hA5, 0, 0, low);
    chk("wr_latency", 32'(low), 32'd3);
    chk("bready_once", 32'(bready_cycles - br0), 32'd1);

    // Read with four wait cycles before RVALID
    r_delay = 4;
    cpu_access(1, 8'h0B, 8'h00, 0, 0, low);
    chk("rd_latency", 32'(low), 32'd7);
    chk("rd_lane3", 32'(o_data), 32'h11);
    r_delay = 0;

    // AW before W, then W before AW
    b0 = cnt_b;
    aw_delay = 0; w_delay = 2;
    cpu_access(0, 8'h10, 8'h3C, 0, 0, low);
    aw_delay = 2; w_delay = 0;
    cpu_access(0, 8'h13, 8'hC3, 0, 0, low);
    chk("one_b_per_write", 32'(cnt_b - b0), 32'd2);
    aw_delay = 0; w_delay = 0;

    // CPU holds i_cs across one write
    b0 = cnt_b; aw0 = cnt_aw;
    cpu_access(0, 8'h31, 8'h5A, 0, 20, low);
    chk("held_cs_one_aw", 32'(cnt_aw - aw0), 32'd1);
    chk("held_cs_one_b", 32'(cnt_b - b0), 32'd1);

    // Error on write, then OKAY read clears it
    cpu_access(0, 8'h20, 8'h77, 1, 0, low);
    chk("err_after_slverr", 32'(o_err), 32'd1);
    cpu_access(1, 8'h0B, 8'h00, 0, 0, low);
    chk("err_after_okay", 32'(o_err), 32'd0);

    // Reset in the middle of a write address phase
    aw_delay = 10; w_delay = 10;
    @(posedge i_clk); #1;
    i_cs = 1'b1; i_rwb = 1'b0; i_addr = 8'h42; i_data = 8'h99;
    @(posedge i_clk); #1;
    i_cs = 1'b0;
    #2;
    chk("pre_rst_awvalid", 32'(M_AXIL_AWVALID), 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_awvalid", 32'(M_AXIL_AWVALID), 32'd0);
    chk("arst_wvalid", 32'(M_AXIL_WVALID), 32'd0);
    chk("arst_o_rdy", 32'(o_rdy), 32'd1);
    chk("arst_o_data", 32'(o_data), 32'd0);
    chk("arst_o_err", 32'(o_err), 32'd0);
    ref_odata = 8'h00;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    aw_delay = 0; w_delay = 0;

    // Randomised traffic
    for (int unsigned n = 0; n < 150; n++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      rd  = 1'($urandom_range(0, 1));
      a   = 8'($urandom);
      d   = 8'($urandom);
      err = ($urandom_range(0, 7) == 0);
      cpu_access(rd, a, d, err, $urandom_range(0, 2), low);
    end

    repeat (3) @(posedge i_clk);
    chk("aw_q_drained", 32'(exp_aw_q.size()), 32'd0);
    chk("w_q_drained", 32'(exp_w_q.size()), 32'd0);
    chk("ar_q_drained", 32'(exp_ar_q.size()), 32'd0);
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_axil_bridge.md
Name: cpu_axil_bridge

Overview:
Converts single-byte CPU bus accesses (8-bit data, byte address) into 32-bit AXI-Lite master transactions for the SD controller register path. It sits directly upstream of the SD controller shadow-register stage and feeds its AXI-Lite slave port. Byte writes become one-lane strobed writes. Byte reads return the addressed lane of the 32-bit word. The CPU is stalled through o_rdy until each transaction completes.

Parameters:
ADDR_WIDTH, 8, CPU byte-address width into the register window (must be >= 3).
AXI_BASE, 32'h0, constant OR-ed into every emitted AXI address.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  async active-low reset
i_cs  in  1  CPU chip select for the register window
i_rwb  in  1  1 = read, 0 = write
i_addr  in  ADDR_WIDTH  CPU byte address
i_data  in  8  CPU write data
o_data  out  8  read data, held until the next read completes
o_rdy  out  1  0 = stall CPU
o_err  out  1  last completed transaction returned a non-OKAY response
M_AXIL_AWVALID/AWREADY/AWADDR[31:0]  out/in/out  write address channel
M_AXIL_WVALID/WREADY/WDATA[31:0]/WSTRB[3:0]  out/in/out/out  write data channel
M_AXIL_BVALID/BREADY/BRESP[1:0]  in/out/in  write response channel
M_AXIL_ARVALID/ARREADY/ARADDR[31:0]  out/in/out  read address channel
M_AXIL_RVALID/RREADY/RDATA[31:0]/RRESP[1:0]  in/out/in/in  read data channel

Behaviour:
- Reset:
  - i_clk is the single clock; i_reset_n is asynchronous, active-low.
  - While asserted: state=IDLE; all VALIDs and READYs 0; o_data=0; o_err=0; o_rdy=1.
  - Reset mid-transaction drops every VALID immediately and discards the capture.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - When i_cs=1, capture i_addr, i_data and i_rwb at that edge.
  - Next state is WR_ADDR_DATA if i_rwb=0, else RD_ADDR.
- o_rdy is combinational:
  - 0 when (state==IDLE && i_cs).
  - 0 in every state other than IDLE and DONE.
  - 1 otherwise.
- Address mapping: AWADDR = ARADDR = AXI_BASE | {addr[ADDR_WIDTH-1:2], 2'b00}. lane = addr[1:0].
- Write path:
  - WDATA = {4{data}}; WSTRB = 4'b0001 << lane.
  - WR_ADDR_DATA asserts AWVALID and WVALID together, both registered.
  - Each VALID deasserts independently on its own handshake. Handshakes may occur in the same cycle or in either order.
  - Once both have completed, go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, set o_err = (BRESP != 0) and go to DONE.
- Read path:
  - RD_ADDR asserts ARVALID until ARREADY, then goes to RD_DATA.
  - RD_DATA: RREADY=1. On RVALID, set o_data = RDATA[lane*8 +: 8] and o_err = (RRESP != 0), then go to DONE.
- DONE: o_rdy=1. Return to IDLE when i_cs=0. This guarantees one transaction per CPU access even if the CPU holds i_cs.
- No timeout. The AXI slave must eventually respond.
- Signals held stable while VALID=1 without READY: AWADDR, WDATA, WSTRB, ARADDR.
- Minimum latency, with zero-wait slave (cycle 0 = i_cs sampled in IDLE):
  - Write: handshake cycle 1, B cycle 2, DONE cycle 3.
  - Read: identical cycle count.
- i_addr, i_data and i_rwb changes after capture are ignored.
- o_data and o_err change only on response acceptance.

Test Plan:
- Write i_addr=8'h05, i_data=8'hA5, slave always ready -> AWADDR=32'h4, WDATA=32'hA5A5A5A5, WSTRB=4'b0010, BREADY pulses once, o_rdy low 3 cycles, o_err=0.
- Read i_addr=8'h0B, RDATA=32'h11223344 after 4 wait cycles -> ARADDR=32'h8, o_data=8'h11, o_rdy stays low until RVALID is accepted.
- Write with AWREADY 2 cycles before WREADY, then the reverse order -> each VALID drops only on its own handshake, and exactly one B is accepted per access.
- i_cs held high for 20 cycles across one write -> exactly one AW/W/B sequence, state parks in DONE, o_rdy=1.
- BRESP=2'b10 on a write, then an OKAY read -> o_err=1 after the write and 0 after the read.
- Assert i_reset_n=0 while AWVALID=1 in WR_ADDR_DATA -> AWVALID/WVALID drop asynchronously, o_rdy=1, o_data=0, state=IDLE.
